// File: rtl/interleaver_pkg.sv
// Shared lane count and lane-index type for the four-way interleaver.
package interleaver_pkg;
    localparam int NUM_LANES = 4;
    typedef logic [1:0] lane_idx_t;
endpackage

// File: rtl/interleaver_out_reg.sv
// Single-entry output register with valid/ready load-hold; reports when it can accept a word.
module interleaver_out_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         can_load_o,
    output logic         valid_o,
    output logic [W-1:0] data_o
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // ready_i only matters while a word is held
    assign can_load_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && ready_i) valid_d = 1'b0;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/interleaver.sv
// Four-lane strict round-robin merger (inverse of the valid deinterleaver).
// Optional source-lane tag output enabled by INTERLEAVER_LANE_TAG_EN.
module interleaver
    import interleaver_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sync_in,
    input  logic              rx0_valid_in,
    input  logic              rx1_valid_in,
    input  logic              rx2_valid_in,
    input  logic              rx3_valid_in,
    input  logic [DATA_W-1:0] rx0_data_in,
    input  logic [DATA_W-1:0] rx1_data_in,
    input  logic [DATA_W-1:0] rx2_data_in,
    input  logic [DATA_W-1:0] rx3_data_in,
    output logic              rx0_ready_out,
    output logic              rx1_ready_out,
    output logic              rx2_ready_out,
    output logic              rx3_ready_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
`ifdef INTERLEAVER_LANE_TAG_EN
    output lane_idx_t         lane_out,
`endif
    input  logic              ready_in
);
`ifdef INTERLEAVER_LANE_TAG_EN
    localparam int PW = DATA_W + $bits(lane_idx_t);
`else
    localparam int PW = DATA_W;
`endif

    logic [NUM_LANES-1:0]             rx_valid, rx_ready;
    logic [NUM_LANES-1:0][DATA_W-1:0] rx_data;
    lane_idx_t                        ptr_q, ptr_d;
    logic                             can_load, xfer;
    logic [PW-1:0]                    ld_payload, out_payload;

    assign rx_valid = {rx3_valid_in, rx2_valid_in, rx1_valid_in, rx0_valid_in};
    assign rx_data  = {rx3_data_in, rx2_data_in, rx1_data_in, rx0_data_in};

    // Gate with rst so all readies drop immediately on reset, not at the next edge
    always_comb begin
        rx_ready = '0;
        if (!rst && can_load && !sync_in) rx_ready[ptr_q] = 1'b1;
    end

    assign {rx3_ready_out, rx2_ready_out, rx1_ready_out, rx0_ready_out} = rx_ready;
    assign xfer = rx_valid[ptr_q] && rx_ready[ptr_q];

    always_comb begin
        ptr_d = ptr_q;
        if (sync_in)   ptr_d = '0;
        else if (xfer) ptr_d = lane_idx_t'(ptr_q + 2'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

`ifdef INTERLEAVER_LANE_TAG_EN
    assign ld_payload = {ptr_q, rx_data[ptr_q]};
    assign {lane_out, data_out} = out_payload;
`else
    assign ld_payload = rx_data[ptr_q];
    assign data_out   = out_payload;
`endif

    interleaver_out_reg #(.W(PW)) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load_i     (xfer),
        .data_i     (ld_payload),
        .ready_i    (ready_in),
        .can_load_o (can_load),
        .valid_o    (valid_out),
        .data_o     (out_payload)
    );
endmodule

// File: tb/tb_interleaver.sv
// Directed + random bench for interleaver; reference model and literal stream checks.
module tb_interleaver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sync_in = 1'b0;
    logic        ready_in = 1'b0;
    logic        rxv [4];
    logic [15:0] rxd [4];
    logic [3:0]  rdy;
    logic        valid_out;
    logic [15:0] data_out;
`ifdef INTERLEAVER_LANE_TAG_EN
    logic [1:0]  lane_out;
`endif
    int checks = 0;
    int failures = 0;

    // model state: what the DUT must hold after the coming edge
    int          m_ptr = 0;
    logic        m_valid = 1'b0;
    logic [15:0] m_data = '0;
    int          m_tag = 0;

    always #5 clk = ~clk;

    interleaver #(.DATA_W(16)) dut (
        .clk(clk), .rst(rst), .sync_in(sync_in),
        .rx0_valid_in(rxv[0]), .rx1_valid_in(rxv[1]),
        .rx2_valid_in(rxv[2]), .rx3_valid_in(rxv[3]),
        .rx0_data_in(rxd[0]), .rx1_data_in(rxd[1]),
        .rx2_data_in(rxd[2]), .rx3_data_in(rxd[3]),
        .rx0_ready_out(rdy[0]), .rx1_ready_out(rdy[1]),
        .rx2_ready_out(rdy[2]), .rx3_ready_out(rdy[3]),
        .valid_out(valid_out), .data_out(data_out),
`ifdef INTERLEAVER_LANE_TAG_EN
        .lane_out(lane_out),
`endif
        .ready_in(ready_in)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Every negedge: compare DUT against model, then advance model across the next edge
    always @(negedge clk) begin
        logic [3:0] exp_rdy;
        logic take;
        if (rst) begin
            m_ptr = 0; m_valid = 1'b0; m_data = '0; m_tag = 0;
            chk("rst_valid", {31'd0, valid_out}, 32'd0);
            chk("rst_data", {16'd0, data_out}, 32'd0);
            chk("rst_ready", {28'd0, rdy}, 32'd0);
        end else begin
            chk("m_valid", {31'd0, valid_out}, {31'd0, m_valid});
            chk("m_data", {16'd0, data_out}, {16'd0, m_data});
`ifdef INTERLEAVER_LANE_TAG_EN
            chk("m_tag", {30'd0, lane_out}, m_tag);
`endif
            exp_rdy = '0;
            if ((!m_valid || ready_in) && !sync_in) exp_rdy[m_ptr] = 1'b1;
            chk("m_ready", {28'd0, rdy}, {28'd0, exp_rdy});
            take = exp_rdy[m_ptr] && rxv[m_ptr];
            if (m_valid && ready_in) m_valid = 1'b0;
            if (take) begin
                m_valid = 1'b1;
                m_data  = rxd[m_ptr];
                m_tag   = m_ptr;
            end
            if (sync_in)   m_ptr = 0;
            else if (take) m_ptr = (m_ptr + 1) % 4;
        end
    end

    task automatic do_reset(input logic v0, input logic v1, input logic v2, input logic v3);
        rst = 1'b1;
        cyc(); cyc();
        rxv[0] = v0; rxv[1] = v1; rxv[2] = v2; rxv[3] = v3;
        for (int k = 0; k < 4; k++) rxd[k] = 16'h1000 + 16'(k);
        ready_in = 1'b1;
        sync_in  = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin rxv[k] = 1'b0; rxd[k] = '0; end
        #2;
        chk("por_valid", {31'd0, valid_out}, 32'd0);
        chk("por_ready", {28'd0, rdy}, 32'd0);

        // Full-rate stream: 1000,1001,1002,1003 repeating
        do_reset(1, 1, 1, 1);
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("stream_valid", {31'd0, valid_out}, 32'd1);
            chk("stream_data", {16'd0, data_out}, 32'h1000 + (i % 4));
`ifdef INTERLEAVER_LANE_TAG_EN
            chk("stream_tag", {30'd0, lane_out}, i % 4);
`endif
        end

        // Lane 1 stalls: no skipping to lanes 2/3
        do_reset(1, 0, 1, 1);
        cyc();
        chk("stall_first", {16'd0, data_out}, 32'h1000);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("stall_idle", {31'd0, valid_out}, 32'd0);
        end
        rxv[1] = 1'b1;
        cyc();
        chk("stall_resume", {16'd0, data_out}, 32'h1001);
        chk("stall_resume_v", {31'd0, valid_out}, 32'd1);
        cyc();
        chk("stall_next", {16'd0, data_out}, 32'h1002);

        // Backpressure holding 0xAAAA
        do_reset(1, 1, 1, 1);
        rxd[0] = 16'hAAAA;
        ready_in = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("hold_data", {16'd0, data_out}, 32'hAAAA);
            chk("hold_ready", {28'd0, rdy}, 32'd0);
            cyc();
        end
        chk("hold_data_last", {16'd0, data_out}, 32'hAAAA);
        ready_in = 1'b1;
        #1;
        chk("hold_release_rdy", {28'd0, rdy}, 32'h2);
        cyc();
        chk("hold_after", {16'd0, data_out}, 32'h1001);

        // Sync with pointer at 2
        do_reset(1, 1, 1, 1);
        cyc(); cyc();
        chk("sync_pre", {16'd0, data_out}, 32'h1001);
        sync_in = 1'b1;
        #1;
        chk("sync_blocks", {28'd0, rdy}, 32'd0);
        cyc();
        sync_in = 1'b0;
        chk("sync_drain", {31'd0, valid_out}, 32'd0);
        chk("sync_keep_data", {16'd0, data_out}, 32'h1001);
        cyc();
        chk("sync_lane0", {16'd0, data_out}, 32'h1000);

        // Asynchronous reset mid-stream
        do_reset(1, 1, 1, 1);
        cyc(); cyc();
        chk("arst_pre", {31'd0, valid_out}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, valid_out}, 32'd0);
        chk("arst_data", {16'd0, data_out}, 32'd0);
        chk("arst_ready", {28'd0, rdy}, 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("arst_lane0", {16'd0, data_out}, 32'h1000);

        // Random traffic under model checking
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++) begin
                rxv[k] = 1'($urandom_range(0, 3) != 0);
                rxd[k] = 16'($urandom);
            end
            ready_in = 1'($urandom_range(0, 2) != 0);
            sync_in  = 1'($urandom_range(0, 24) == 0);
            cyc();
        end
        sync_in = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
